// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential radix-4 Booth multiplier
// between two requesters; returns the captured product tagged with its owner.
module booth_mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_id,
  output logic [2*WIDTH-1:0]   res_prod,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_load,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       grant_c;
  logic             sel_c;

  // Grant only while idle; on contention the requester named by rr_ptr wins.
  always_comb begin
    grant_c = 2'b00;
    if (state == IDLE) begin
      unique case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_ptr ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign sel_c     = grant_c[1];
  assign req_ready = grant_c;
  assign mul_a     = op_a;
  assign mul_b     = op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res_prod  <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      mul_load  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_c != 2'b00) begin
            op_a     <= sel_c ? req_a1 : req_a0;
            op_b     <= sel_c ? req_b1 : req_b0;
            owner    <= sel_c;
            rr_ptr   <= ~sel_c;
            mul_load <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          mul_load <= 1'b0;
          cnt      <= CNT_W'(1);
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          // Product is valid MUL_LAT cycles after the load cycle.
          if (cnt == CNT_W'(MUL_LAT)) begin
            res_prod  <= mul_prod;
            res_id    <= owner;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter: a transaction-level model predicts
// grants, strobes and tagged products; a stand-in multiplier serves the datapath.
module tb_booth_mult_arbiter;

  localparam int MUL_LAT = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_a0, req_b0, req_a1, req_b1;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [15:0] res_prod;
  logic [7:0]  mul_a, mul_b;
  logic        mul_load;
  logic [15:0] mul_prod;
  logic        busy;

  booth_mult_arbiter #(.WIDTH(8), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_prod(res_prod),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_prod(mul_prod),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    return 16'(ai * bi);
  endfunction

  // Stand-in multiplier: product valid MUL_LAT cycles after the load cycle, garbage before.
  logic [15:0] mp_val = 16'h0;
  int          mp_rem = 0;
  always @(posedge clk) begin
    if (mul_load) begin
      mp_val <= mul_ref(mul_a, mul_b);
      mp_rem <= MUL_LAT - 1;
    end else if (mp_rem > 0) begin
      mp_rem <= mp_rem - 1;
    end
  end
  assign mul_prod = (mp_rem == 0) ? mp_val : ~mp_val;

  // Result-consumer behaviour, selected by the stimulus process.
  bit rr_random = 1'b0;
  bit rr_force  = 1'b1;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_random ? ($urandom_range(0, 2) != 0) : rr_force;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   timeouts   = 0;
  bit   stim_done  = 1'b0;

  bit         pend      = 1'b0;
  int         age       = 0;
  logic       m_rr      = 1'b0;
  bit         after_rst = 1'b0;
  int         cycles    = 0;
  logic [1:0] eg;
  bit         exp_v;
  exp_t       e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cycles++;
      if (cycles > 60000) begin
        check("watchdog", 32'(cycles), 32'(60000));
        summary();
        $finish;
      end
      if (rst) begin
        sb.delete();
        pend      = 1'b0;
        age       = 0;
        m_rr      = 1'b0;
        after_rst = 1'b1;
      end else begin
        if (pend) age++;
        eg = 2'b00;
        if (!pend) begin
          if (req_valid == 2'b11)      eg = m_rr ? 2'b10 : 2'b01;
          else                         eg = req_valid;
        end
        exp_v = pend && (age >= MUL_LAT + 2);
        check("req_ready", 32'(req_ready), 32'(eg));
        check("busy", 32'(busy), 32'(pend));
        check("mul_load", 32'(mul_load), 32'(pend && age == 1));
        check("res_valid", 32'(res_valid), 32'(exp_v));
        if (after_rst) begin
          check("rst_res_prod", 32'(res_prod), 32'(0));
          check("rst_res_id", 32'(res_id), 32'(0));
          check("rst_mul_a", 32'(mul_a), 32'(0));
          check("rst_mul_b", 32'(mul_b), 32'(0));
          after_rst = 1'b0;
        end
        if (pend && age == 1 && sb.size() > 0) begin
          check("mul_a", 32'(mul_a), 32'(sb[0].a));
          check("mul_b", 32'(mul_b), 32'(sb[0].b));
        end
        if (exp_v && sb.size() > 0) begin
          check("res_id", 32'(res_id), 32'(sb[0].id));
          check("res_prod", 32'(res_prod), 32'(sb[0].prod));
          if (res_ready) begin
            void'(sb.pop_front());
            pend = 1'b0;
          end
        end
        if (eg != 2'b00) begin
          e.id   = eg[1];
          e.a    = eg[1] ? req_a1 : req_a0;
          e.b    = eg[1] ? req_b1 : req_b0;
          e.prod = mul_ref(e.a, e.b);
          sb.push_back(e);
          pend = 1'b1;
          age  = 0;
          m_rr = ~eg[1];
        end
        if (stim_done) begin
          check("stim_timeouts", 32'(timeouts), 32'(0));
          check("drained", 32'({pend, 8'(sb.size())}), 32'(0));
          summary();
          $finish;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] v, input int a0, input int b0,
                       input int a1, input int b1, input bit jitter);
    logic [1:0] pending;
    logic [1:0] acc;
    int t;
    pending   = v;
    t         = 0;
    req_a0    = 8'(a0);
    req_b0    = 8'(b0);
    req_a1    = 8'(a1);
    req_b1    = 8'(b1);
    req_valid = v;
    while (pending != 2'b00 && t < 400) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      pending   = pending & ~acc;
      req_valid = pending;
      if (jitter) begin
        if (pending[0]) begin req_a0 = 8'($urandom); req_b0 = 8'($urandom); end
        if (pending[1]) begin req_a1 = 8'($urandom); req_b1 = 8'($urandom); end
      end
      t++;
    end
    if (pending != 2'b00) begin
      timeouts++;
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_res_valid();
    int t;
    t = 0;
    while (!res_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!res_valid) timeouts++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a0 = 8'h0; req_b0 = 8'h0; req_a1 = 8'h0; req_b1 = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single request from requester 0.
    drive(2'b01, -38, 55, 0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back on requester 1 alone.
    drive(2'b10, 0, 0, 78, 82, 1'b0);
    drive(2'b10, 0, 0, 57, -63, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Backpressure with requester 1 waiting.
    rr_force = 1'b0;
    drive(2'b01, -55, -46, 0, 0, 1'b0);
    req_a1 = 8'(111);
    req_b1 = 8'(111);
    req_valid = 2'b10;
    wait_res_valid();
    repeat (10) @(posedge clk);
    #1 rr_force = 1'b1;
    drive(2'b10, 0, 0, 111, 111, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Abort mid-RUN, then contention resolved from a cleared pointer.
    drive(2'b01, 3, 4, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_a0 = 8'(5);   req_b0 = 8'(9);
    req_a1 = 8'(-99); req_b1 = 8'(91);
    req_valid = 2'b11;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(2'b11, 5, 9, -99, 91, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Corner operands.
    drive(2'b01, -128, -128, 0, 0, 1'b0);
    drive(2'b01, -128, 127, 0, 0, 1'b0);
    drive(2'b10, 0, 0, 0, 77, 1'b0);
    drive(2'b10, 0, 0, 127, 127, 1'b0);

    // Randomized traffic with random consumer backpressure.
    rr_random = 1'b1;
    for (int i = 0; i < 150; i++) begin
      drive(2'($urandom_range(1, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    rr_random = 1'b0;
    rr_force  = 1'b1;
    repeat (20) @(posedge clk);
    #1 stim_done = 1'b1;
  end

endmodule
